// File: rtl/accum_seq_pkg.sv
// Shared types for the accumulator sequencer: FSM state encoding and the
// bit positions of the {S, E, B} program entry word.
package accum_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Entry word layout for a DW-bit operand: {S, E, B[DW-1:0]}.
    function automatic int entry_s_bit(input int dw);
        return dw + 1;
    endfunction

    function automatic int entry_e_bit(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/accum_prog_ram.sv
// Program store for the sequencer: DEPTH x (DW+2) register file with a
// synchronous write port and a combinational read port. Not reset.
module accum_prog_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW+1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW+1:0] rdata
);

    logic [DW+1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/accum_sequencer.sv
// Steps the 8-bit accumulator through a stored program of {S, E, B} words,
// one per cycle, then captures the accumulator output and pulses done.
module accum_sequencer
    import accum_seq_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW+1:0] wr_data,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic [DW-1:0] Q,
    output logic          acc_clr,
    output logic [DW-1:0] B,
    output logic          S,
    output logic          E,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result
);

    localparam int S_BIT = entry_s_bit(DW);
    localparam int E_BIT = entry_e_bit(DW);
    localparam logic [AW:0] DEPTH_N = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    state_t state, next_state;
    logic [AW:0]   n;
    logic [AW:0]   pc;
    logic [DW+1:0] entry;
    logic          last_step;

    assign last_step = (state == RUN) && ((pc + ONE) == n);

    accum_prog_ram #(.AW(AW), .DW(DW)) u_ram (
        .CLK   (CLK),
        .we    (wr_en && (state == IDLE)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc[AW-1:0]),
        .rdata (entry)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs decode straight from the registered state, so they still
    // change only on the clock edge and the accumulator has half a cycle
    // of setup before its negedge sample.
    always_comb begin
        next_state = state;
        acc_clr    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        B          = '0;
        S          = 1'b0;
        E          = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = CLEAR;
            end
            CLEAR: begin
                acc_clr    = 1'b1;
                busy       = 1'b1;
                next_state = (n != '0) ? RUN : DONE;
            end
            RUN: begin
                busy = 1'b1;
                B    = entry[DW-1:0];
                S    = entry[S_BIT];
                E    = entry[E_BIT];
                if (last_step) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // pc, step count and result capture; len is clamped to the program depth.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc     <= '0;
            n      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n  <= (len > DEPTH_N) ? DEPTH_N : len;
                        pc <= '0;
                    end
                end
                CLEAR: begin
                    if (n == '0) result <= '0;
                end
                RUN: begin
                    pc <= pc + ONE;
                    if (last_step) result <= Q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer driving a behavioural 8-bit accumulator
// as its load; table-driven program runs plus hand-written corner sequences.
module tb_accum_sequencer;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [9:0] wr_data;
    logic [4:0] len;
    logic       start;
    logic [7:0] Q;
    logic       acc_clr;
    logic [7:0] B;
    logic       S;
    logic       E;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int passCount  = 0;
    int checkCount = 0;

    int         doneAt;
    int         busyCount;
    int         overlap;
    logic [7:0] bseq[$];

    typedef struct {
        string           name;
        int              nent;
        logic [3:0][9:0] prog;
        logic [4:0]      lenIn;
        logic [7:0]      expResult;
    } vec_t;

    vec_t vecs[5];

    accum_sequencer #(.AW(4), .DW(8)) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .start   (start),
        .Q       (Q),
        .acc_clr (acc_clr),
        .B       (B),
        .S       (S),
        .E       (E),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 CLK = ~CLK;

    // Accumulator load: samples its controls on the negedge.
    always @(negedge CLK) begin
        if (acc_clr)      Q <= 8'd0;
        else if (E && S)  Q <= Q - B;
        else if (E)       Q <= Q + B;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic writeEntry(input logic [3:0] addr, input logic [9:0] data);
        @(posedge CLK); #1;
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge CLK); #1;
        wr_en = 1'b0;
    endtask

    // Starts a run and watches it to completion, optionally firing a start
    // pulse and a write to addr 0 in the second RUN cycle.
    task automatic applyStimulus(input logic [4:0] lenIn, input bit inject);
        @(posedge CLK); #1;
        len = lenIn; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; len = 5'd0;
        doneAt = 0; busyCount = 0; overlap = 0;
        bseq.delete();
        for (int k = 1; k <= 40; k++) begin
            if (busy) busyCount++;
            if (busy && done) overlap++;
            if (busy && !acc_clr) bseq.push_back(B);
            if (inject && k == 4) begin start = 1'b0; wr_en = 1'b0; end
            if (inject && k == 3) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 10'h163;
            end
            if (done) begin doneAt = k; break; end
            @(posedge CLK); #1;
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic checkRun(input string name, input logic [4:0] lenIn, input logic [7:0] expResult);
        int nExp;
        nExp = (lenIn > 5'd16) ? 16 : int'(lenIn);
        checkOutput({name, " done latency"}, doneAt, nExp + 2);
        checkOutput({name, " busy cycles"}, busyCount, nExp + 1);
        checkOutput({name, " busy/done overlap"}, overlap, 0);
        checkOutput({name, " result"}, int'(result), int'(expResult));
        @(posedge CLK); #1;
        checkOutput({name, " done width"}, int'(done), 0);
    endtask

    initial begin
        vecs[0] = '{"basic", 3, {10'h000, 10'h302, 10'h103, 10'h105}, 5'd3, 8'd6};
        vecs[1] = '{"wrap",  2, {10'h000, 10'h000, 10'h164, 10'h1C8}, 5'd2, 8'd44};
        vecs[2] = '{"sub",   1, {10'h000, 10'h000, 10'h000, 10'h332}, 5'd1, 8'd206};
        vecs[3] = '{"len0",  0, {10'h000, 10'h000, 10'h000, 10'h000}, 5'd0, 8'd0};
        vecs[4] = '{"hold",  3, {10'h000, 10'h304, 10'h04D, 10'h10A}, 5'd3, 8'd6};

        CLR = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; start = 1'b0; Q = 8'd0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset busy",    int'(busy),    0);
        checkOutput("reset done",    int'(done),    0);
        checkOutput("reset acc_clr", int'(acc_clr), 0);
        checkOutput("reset BSE",     int'({B, S, E}), 0);
        checkOutput("reset result",  int'(result),  0);
        CLR = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].nent; i++) writeEntry(4'(i), vecs[v].prog[i]);
            applyStimulus(vecs[v].lenIn, 1'b0);
            checkOutput({vecs[v].name, " B count"}, bseq.size(), vecs[v].nent);
            for (int i = 0; i < vecs[v].nent && i < bseq.size(); i++)
                checkOutput($sformatf("%s B[%0d]", vecs[v].name, i), int'(bseq[i]),
                            int'(vecs[v].prog[i][7:0]));
            checkRun(vecs[v].name, vecs[v].lenIn, vecs[v].expResult);
        end

        // len above depth runs every entry once.
        for (int i = 0; i < 16; i++) writeEntry(4'(i), 10'h101);
        applyStimulus(5'd20, 1'b0);
        checkRun("clamp", 5'd20, 8'd16);

        // Requests during RUN are ignored; mem[0] stays 7 for the rerun.
        writeEntry(4'd0, 10'h107);
        writeEntry(4'd1, 10'h108);
        applyStimulus(5'd2, 1'b1);
        checkRun("ignored", 5'd2, 8'd15);
        applyStimulus(5'd2, 1'b0);
        checkRun("mem kept", 5'd2, 8'd15);

        // CLR in the second RUN cycle aborts the run with no done pulse.
        writeEntry(4'd0, 10'h105);
        writeEntry(4'd1, 10'h103);
        writeEntry(4'd2, 10'h302);
        @(posedge CLK); #1;
        len = 5'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #2 CLR = 1'b1;
        #1;
        checkOutput("abort busy",   int'(busy),   0);
        checkOutput("abort BSE",    int'({B, S, E}), 0);
        checkOutput("abort result", int'(result), 0);
        @(posedge CLK); #1;
        CLR = 1'b0;
        begin
            int doneSeen = 0;
            repeat (5) begin
                if (done || busy) doneSeen++;
                @(posedge CLK); #1;
            end
            checkOutput("abort no done", doneSeen, 0);
        end
        applyStimulus(5'd3, 1'b0);
        checkRun("after abort", 5'd3, 8'd6);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
